seg7_ticker: RTL and testbench
==============================

# seg7_ticker

Single-digit seven-segment counter stage for the Pygmy board display. A programmable prescaler divides `clk` into count ticks. Each tick steps a 4-bit digit up or down with wrap-around. The digit is decoded into registered segment drives on `leda`..`ledg`, and tick and wrap pulses are exported so an indicator-LED stage or a further digit can chain off this one.

## Interface
Parameters:
- `TICK_DIV`, default 4000000: clk cycles per count step; legal range 2..2^24.
- `MAX_DIGIT`, default 9: highest digit value; legal range 1..15.
- `SEG_ACTIVE_LOW`, default 0: 1 inverts all seven segment outputs.

Ports:
- `clk` in 1: system clock (Sys_Clk0).
- `rst` in 1: reset; one clock; reset is synchronous and active-high.
- `en` in 1: count enable; prescaler advances only while high.
- `dir` in 1: 0 = count up, 1 = count down.
- `load` in 1: synchronous load strobe.
- `load_val` in 4: value written on `load`.
- `digit` out 4: current digit, registered.
- `leda`..`ledg` out 1 each: segments a..g, registered, polarity per `SEG_ACTIVE_LOW`.
- `tick` out 1: one-cycle pulse on every count step.
- `wrap` out 1: one-cycle pulse on a wrapping count step.

## Operation
- Prescaler `pre` is 24 bits.
- Priority on every rising edge: `rst` > `load` > count > hold.
- `rst`:
  - `pre`=0, `digit`=0, `tick`=0, `wrap`=0.
  - Segments show "0": a–f on, g off (then polarity applied).
- `load`:
  - `digit` = `load_val`, clamped to `MAX_DIGIT` if larger.
  - `pre`=0, `tick`=0, `wrap`=0.
  - `en` and `dir` are ignored this cycle.
- Count, `en`=1:
  - If `pre` < `TICK_DIV`-1: `pre`++, `tick`=0, `wrap`=0.
  - If `pre` == `TICK_DIV`-1: `pre`=0, `tick`=1, and the digit steps.
  - Step up: `digit`+1. At `MAX_DIGIT` it goes to 0 with `wrap`=1.
  - Step down: `digit`-1. At 0 it goes to `MAX_DIGIT` with `wrap`=1.
- Hold, `en`=0: `pre` and `digit` hold; `tick`=0, `wrap`=0.
- `dir` is sampled only on the step cycle; changing it between steps has no effect on `pre`.
- Segment decode, from the next-state digit, so segments are always aligned with `digit`:
  - 0: abcdef; 1: bc; 2: abdeg; 3: abcdg; 4: bcfg; 5: acdfg; 6: acdefg; 7: abc
  - 8: abcdefg; 9: abcdfg; A: abcefg; b: cdefg; C: adef; d: bcdeg; E: adefg; F: aefg
- `digit` never exceeds `MAX_DIGIT` after reset.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- From `en` rising with `pre`=0: first `tick` and digit change appear `TICK_DIV` edges later, then every `TICK_DIV` cycles.
- `tick`, `wrap`, the new `digit` and the new segments all become valid on the same edge and last exactly one cycle (pulses) or until the next change (digit, segments).
- `load` has one-cycle latency: `digit` and segments update on the edge that samples `load`.
- `load` coincident with a prescaler terminal count: load wins, no `tick`, and the next tick is a full `TICK_DIV` cycles away.
- `rst` mid-count: prescaler progress is discarded; outputs take reset values on that edge.
- Held `load`: reloads every cycle and counting is suppressed.

## Test plan
Bench parameters: `TICK_DIV`=4, `MAX_DIGIT`=9, `SEG_ACTIVE_LOW`=0.
1. Reset: `rst`=1 for 2 cycles with `en`=1 -> `digit`=0, a–f=1, g=0, `tick`=`wrap`=0 throughout.
2. Count up: release `rst` with `en`=1, `dir`=0 -> `tick` pulses on cycles 4, 8, 12; digit goes 1, 2, 3; at digit 1 only b and c are high.
3. Wrap up: `load`=1 with `load_val`=9, then count -> after 4 cycles `digit`=0 with `tick`=`wrap`=1 for one cycle; segments abcdef.
4. Wrap down: `digit`=0, `dir`=1 -> after 4 cycles `digit`=9, `wrap`=1; segments abcdfg.
5. Clamp and priority:
   - `load_val`=12 -> `digit`=9.
   - `load` asserted on a terminal-count cycle -> no `tick`; next tick 4 cycles after load.
6. Hold and reset: drop `en` with `pre`=2 for 10 cycles -> no change; re-enable -> `tick` 2 cycles later. Then `rst` with `pre`=3 -> reset values on that edge.

Source files
------------

// File: rtl/seg7_ticker.sv
// rtl/seg7_ticker.sv - prescaled single-digit up/down counter with registered seven-segment drive
// Tick and wrap pulses are exported so further digits or indicator stages can chain off this one.
module seg7_ticker #(
  parameter int TICK_DIV       = 4000000,
  parameter int MAX_DIGIT      = 9,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] digit,
  output logic       leda,
  output logic       ledb,
  output logic       ledc,
  output logic       ledd,
  output logic       lede,
  output logic       ledf,
  output logic       ledg,
  output logic       tick,
  output logic       wrap
);

  localparam logic [23:0] TERM    = 24'(TICK_DIV - 1);
  localparam logic [3:0]  MAX_D   = 4'(MAX_DIGIT);
  localparam logic [6:0]  SEG_INV = {7{SEG_ACTIVE_LOW}};

  // Segment vector ordered {a,b,c,d,e,f,g}, active-high before polarity is applied.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'h0:    seg_decode = 7'b1111110;
      4'h1:    seg_decode = 7'b0110000;
      4'h2:    seg_decode = 7'b1101101;
      4'h3:    seg_decode = 7'b1111001;
      4'h4:    seg_decode = 7'b0110011;
      4'h5:    seg_decode = 7'b1011011;
      4'h6:    seg_decode = 7'b1011111;
      4'h7:    seg_decode = 7'b1110000;
      4'h8:    seg_decode = 7'b1111111;
      4'h9:    seg_decode = 7'b1111011;
      4'hA:    seg_decode = 7'b1110111;
      4'hB:    seg_decode = 7'b0011111;
      4'hC:    seg_decode = 7'b1001110;
      4'hD:    seg_decode = 7'b0111101;
      4'hE:    seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  logic [23:0] pre, pre_nxt;
  logic [3:0]  digit_nxt;
  logic        tick_nxt, wrap_nxt;
  logic [6:0]  seg_q, seg_nxt;

  always_comb begin
    pre_nxt   = pre;
    digit_nxt = digit;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    if (load) begin
      digit_nxt = (load_val > MAX_D) ? MAX_D : load_val;
      pre_nxt   = '0;
    end else if (en) begin
      if (pre == TERM) begin
        pre_nxt  = '0;
        tick_nxt = 1'b1;
        if (dir) begin
          if (digit == 4'd0) begin
            digit_nxt = MAX_D;
            wrap_nxt  = 1'b1;
          end else begin
            digit_nxt = digit - 4'd1;
          end
        end else if (digit >= MAX_D) begin
          digit_nxt = 4'd0;
          wrap_nxt  = 1'b1;
        end else begin
          digit_nxt = digit + 4'd1;
        end
      end else begin
        pre_nxt = pre + 24'd1;
      end
    end
    // Decoding the next-state digit keeps segments in step with the digit register.
    seg_nxt = seg_decode(digit_nxt) ^ SEG_INV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre   <= '0;
      digit <= 4'd0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      seg_q <= seg_decode(4'd0) ^ SEG_INV;
    end else begin
      pre   <= pre_nxt;
      digit <= digit_nxt;
      tick  <= tick_nxt;
      wrap  <= wrap_nxt;
      seg_q <= seg_nxt;
    end
  end

  assign {leda, ledb, ledc, ledd, lede, ledf, ledg} = seg_q;

endmodule

// File: tb/tb_seg7_ticker.sv
// tb/tb_seg7_ticker.sv - directed vector bench for seg7_ticker with TICK_DIV=4, MAX_DIGIT=9
module tb_seg7_ticker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] digit;
  logic       leda, ledb, ledc, ledd, lede, ledf, ledg;
  logic       tick, wrap;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  seg7_ticker #(.TICK_DIV(4), .MAX_DIGIT(9), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .digit(digit), .leda(leda), .ledb(ledb), .ledc(ledc), .ledd(ledd),
    .lede(lede), .ledf(ledf), .ledg(ledg), .tick(tick), .wrap(wrap)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_digit;
    logic       exp_tick;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[$];
  logic [6:0] seg_ref[16];

  task automatic add(input logic r, input logic e, input logic d, input logic l,
                     input logic [3:0] lv, input logic [3:0] ed, input logic et, input logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.dir = d; v.load = l; v.load_val = lv;
    v.exp_digit = ed; v.exp_tick = et; v.exp_wrap = ew;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic apply_and_check(input vec_t v, input int idx);
    rst = v.rst; en = v.en; dir = v.dir; load = v.load; load_val = v.load_val;
    @(posedge clk);
    #1;
    check("digit", idx, {3'b0, digit}, {3'b0, v.exp_digit});
    check("segments", idx, {leda, ledb, ledc, ledd, lede, ledf, ledg}, seg_ref[v.exp_digit]);
    check("tick", idx, {6'b0, tick}, {6'b0, v.exp_tick});
    check("wrap", idx, {6'b0, wrap}, {6'b0, v.exp_wrap});
  endtask

  initial begin
    seg_ref[0]  = 7'b1111110; seg_ref[1]  = 7'b0110000; seg_ref[2]  = 7'b1101101;
    seg_ref[3]  = 7'b1111001; seg_ref[4]  = 7'b0110011; seg_ref[5]  = 7'b1011011;
    seg_ref[6]  = 7'b1011111; seg_ref[7]  = 7'b1110000; seg_ref[8]  = 7'b1111111;
    seg_ref[9]  = 7'b1111011; seg_ref[10] = 7'b1110111; seg_ref[11] = 7'b0011111;
    seg_ref[12] = 7'b1001110; seg_ref[13] = 7'b0111101; seg_ref[14] = 7'b1001111;
    seg_ref[15] = 7'b1000111;

    // Reset held two cycles with en high
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    // Count up: tick on cycles 4, 8, 12
    for (int k = 1; k <= 12; k++)
      add(0, 1, 0, 0, 0, 4'(k / 4), (k % 4) == 0, 0);
    // Wrap up from 9
    add(0, 1, 0, 1, 9, 9, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // Wrap down from 0, then a plain down step
    add(0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 9, 1, 1);
    add(0, 1, 1, 0, 0, 9, 0, 0);
    add(0, 1, 1, 0, 0, 9, 0, 0);
    add(0, 1, 1, 0, 0, 9, 0, 0);
    add(0, 1, 1, 0, 0, 8, 1, 0);
    // Clamp
    add(0, 0, 0, 1, 12, 9, 0, 0);
    add(0, 0, 0, 1, 15, 9, 0, 0);
    // Load on terminal count: no tick, next tick a full period later
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 0, 0, 9, 0, 0);
    add(0, 1, 0, 1, 5, 5, 0, 0);
    add(0, 1, 0, 0, 0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 5, 0, 0);
    add(0, 1, 0, 0, 0, 6, 1, 0);
    // Held load suppresses counting
    for (int k = 0; k < 6; k++)
      add(0, 1, 0, 1, 2, 2, 0, 0);
    add(0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 2, 0, 0);
    add(0, 1, 0, 0, 0, 3, 1, 0);

    for (int i = 0; i < vecs.size(); i++)
      apply_and_check(vecs[i], i);

    // Hold with pre=2, resume: tick two cycles after re-enable
    begin
      vec_t v;
      int base;
      base = 1000;
      v.rst = 0; v.dir = 0; v.load_val = 4;
      v.en = 1; v.load = 1; v.exp_digit = 4; v.exp_tick = 0; v.exp_wrap = 0;
      apply_and_check(v, base);
      v.load = 0;
      apply_and_check(v, base + 1);
      apply_and_check(v, base + 2);
      v.en = 0;
      for (int k = 0; k < 10; k++)
        apply_and_check(v, base + 3 + k);
      v.en = 1;
      apply_and_check(v, base + 13);
      v.exp_digit = 5; v.exp_tick = 1;
      apply_and_check(v, base + 14);
      // Bring pre to 3, then reset mid-count
      v.exp_tick = 0;
      for (int k = 0; k < 3; k++)
        apply_and_check(v, base + 15 + k);
      v.rst = 1; v.exp_digit = 0;
      apply_and_check(v, base + 18);
      v.rst = 0;
      for (int k = 0; k < 3; k++)
        apply_and_check(v, base + 19 + k);
      v.exp_digit = 1; v.exp_tick = 1;
      apply_and_check(v, base + 22);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
